// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer advanced by rising edges of a sampled slow_clk.
// Optional alarm output enabled by defining COUNTDOWN_TIMER_ALARM_EN.
module countdown_timer #(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clock_in,
  input  logic       clear_n,
  input  logic       slow_clk,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic        slow_q, armed_q, tick;
  logic [1:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        running_q, done_q;

  // armed_q blocks a spurious tick when slow_clk is already high at reset release
  assign tick = slow_clk & ~slow_q & armed_q;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd0) begin
      r[3:0] = c[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (c[7:4] != 4'd0) begin
        r[7:4] = c[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (c[11:8] != 4'd0) begin
          r[11:8] = c[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = c[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (load) begin
      count_d = {clamp_digit(preset_min[7:4], 4'd9), clamp_digit(preset_min[3:0], 4'd9),
                 clamp_digit(preset_sec[7:4], 4'd5), clamp_digit(preset_sec[3:0], 4'd9)};
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (start) state_d = (count_q != 16'h0000) ? RUN : DONE;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick && count_q != 16'h0000) begin
            count_d = bcd_dec(count_q);
            if (count_q == 16'h0001) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge clear_n) begin
    if (!clear_n) begin
      slow_q    <= 1'b0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      count_q   <= 16'h0000;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      slow_q    <= slow_clk;
      armed_q   <= 1'b1;
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

`ifdef COUNTDOWN_TIMER_ALARM_EN
  localparam int unsigned ACW = $clog2(ALARM_TICKS + 1);

  logic           alarm_q, alarm_d;
  logic [ACW-1:0] acnt_q, acnt_d;

  always_comb begin
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (state_d == DONE && state_q != DONE) begin
      alarm_d = 1'b1;
      acnt_d  = '0;
    end else if (state_d != DONE) begin
      alarm_d = 1'b0;
    end else if (tick && acnt_q != ACW'(ALARM_TICKS)) begin
      acnt_d  = acnt_q + ACW'(1);
      alarm_d = (acnt_d == ACW'(ALARM_TICKS)) ? 1'b0 : ~alarm_q;
    end
  end

  always_ff @(posedge clock_in or negedge clear_n) begin
    if (!clear_n) begin
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else begin
      alarm_q <= alarm_d;
      acnt_q  <= acnt_d;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  assign min_bcd = count_q[15:8];
  assign sec_bcd = count_q[7:0];
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter: ALARM_TICKS, 10, number of slow-clock ticks the alarm stays active in DONE.
REQ-002 SHALL have port: clock_in  input  1  system clock, 50 MHz, all flops on its rising edge.
REQ-003 SHALL have port: clear_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: slow_clk  input  1  divided clock from clock divider, treated as data, never used as a clock.
REQ-005 SHALL have port: load  input  1  single-cycle pulse, copy preset into count.
REQ-006 SHALL have port: start  input  1  single-cycle pulse, begin/resume countdown.
REQ-007 SHALL have port: pause  input  1  single-cycle pulse, halt countdown.
REQ-008 SHALL have port: preset_min  input  8  two BCD digits, minutes.
REQ-009 SHALL have port: preset_sec  input  8  two BCD digits, seconds.
REQ-010 SHALL have port: min_bcd  output  8  current minutes, BCD.
REQ-011 SHALL have port: sec_bcd  output  8  current seconds, BCD.
REQ-012 SHALL have port: running  output  1  high only in state RUN.
REQ-013 SHALL have port: done  output  1  high only in state DONE.
REQ-014 SHALL have port: alarm  output  1  alarm indicator.

Function
REQ-015 SHALL register slow_clk once (slow_q) and generate tick for one cycle when slow_clk=1 and slow_q=0.
REQ-016 SHALL implement states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-017 SHALL, on load in any state, copy preset into count and enter IDLE next cycle; load has priority over start, pause, tick.
REQ-018 SHALL clamp preset digits on load: minute/second units >9 -> 9, minute tens >9 -> 9, second tens >5 -> 5.
REQ-019 SHALL, on start in IDLE or PAUSE, enter RUN if count is nonzero, else enter DONE; start ignored in RUN and DONE.
REQ-020 SHALL, on pause in RUN, enter PAUSE; pause ignored in other states.
REQ-021 SHALL decrement count by one second only on tick while in RUN and no load/pause that cycle; count visible on outputs the cycle after tick.
REQ-022 SHALL decrement in BCD: sec units 0->9 borrow; sec tens 0->5 borrow; min units 0->9 borrow; min tens decrement.
REQ-023 SHALL, when a tick in RUN takes count 00:01 -> 00:00, enter DONE in that same update cycle.
REQ-024 SHALL never decrement below 00:00; DONE left only by load or reset.
REQ-025 SHALL not decrement on a tick coinciding with start; first decrement occurs at next tick.

Reset
REQ-026 SHALL, while clear_n=0, force state IDLE, count 00:00, slow_q 0, running 0, done 0, alarm 0, alarm counter 0, immediately and independent of clock_in.
REQ-027 SHALL resume normal operation on the first clock_in edge after clear_n rises; a slow_clk already high at release SHALL NOT produce a tick.

Configuration
REQ-028 SHALL honour macro COUNTDOWN_TIMER_ALARM_EN: defined -> alarm is 1 on DONE entry, toggles on each tick in DONE, forced 0 after ALARM_TICKS ticks, and rearmed only by a new DONE entry.
REQ-029 SHALL, with COUNTDOWN_TIMER_ALARM_EN undefined, tie alarm to 0 and omit the alarm counter; all other behaviour is unchanged.

Verification
REQ-030 SHALL cover: load 01:00, start, 1 tick -> min_bcd=00, sec_bcd=59, running=1.
REQ-031 SHALL cover: load 00:02, start, 2 ticks -> 00:00, done=1, running=0 on same cycle; further ticks leave 00:00.
REQ-032 SHALL cover: load 10:00 in RUN, pause coincident with tick -> PAUSE, count unchanged; start -> RUN; next tick -> 09:59.
REQ-033 SHALL cover: load preset_min=8'h9F, preset_sec=8'h7A -> count 99:59; start with 00:00 -> done=1 next cycle.
REQ-034 SHALL cover: clear_n low mid-RUN at 05:30 -> outputs 00:00, IDLE before next clock edge; slow_clk high at release -> no tick.
REQ-035 SHALL cover, with COUNTDOWN_TIMER_ALARM_EN: DONE entry -> alarm=1, toggles on 10 ticks, then 0; without macro alarm stays 0.
